// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for one arbiter port: request/address/data in, done/err/read data back.
// The requester holds req with stable fields until done, and the arbiter latches them at grant.
interface mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input done, err, rdata);
  modport slave  (input req, we, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sequencing one IDLE/ACCESS/COMPLETE access at a time onto a single-port RAM.
// done pulses one cycle after grant; a losing port simply waits with req held and is never dropped.
module mem_arbiter #(
  parameter int            AW         = 11,
  parameter int            DW         = 16,
  parameter logic [AW-1:0] MAX_ADDR   = 11'h204,
  parameter bit            FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset_bar,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  state_t        state;
  logic          gnt_id;
  logic          prefer_p1;
  logic          done0, done1, err0, err1;
  logic [DW-1:0] cap0, cap1;

  logic          pick_p1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Port 1 wins only if it is alone, or if round-robin currently favours it.
  assign pick_p1   = p1.req && (!p0.req || (!FIXED_PRIO && prefer_p1));
  assign sel_we    = pick_p1 ? p1.we    : p0.we;
  assign sel_addr  = pick_p1 ? p1.addr  : p0.addr;
  assign sel_wdata = pick_p1 ? p1.wdata : p0.wdata;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state     <= IDLE;
      gnt_id    <= 1'b0;
      prefer_p1 <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      cap0      <= '0;
      cap1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0.req || p1.req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            gnt_id    <= pick_p1;
            prefer_p1 <= !pick_p1;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we && (sel_addr <= MAX_ADDR);
          end
        end
        ACCESS: begin
          state  <= COMPLETE;
          mem_we <= 1'b0;
          done0  <= !gnt_id;
          done1  <= gnt_id;
          err0   <= !gnt_id && (mem_addr > MAX_ADDR);
          err1   <= gnt_id && (mem_addr > MAX_ADDR);
        end
        COMPLETE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          if (gnt_id) cap1 <= mem_rdata;
          else        cap0 <= mem_rdata;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // The winner sees live RAM data during COMPLETE; otherwise each port holds its last result.
  assign p0.done  = done0;
  assign p0.err   = err0;
  assign p0.rdata = done0 ? mem_rdata : cap0;
  assign p1.done  = done1;
  assign p1.err   = err1;
  assign p1.rdata = done1 ? mem_rdata : cap1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance on a modelled RAM plus a fixed-priority instance.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_bar;
  logic [10:0] mem_addr, f_mem_addr;
  logic [15:0] mem_wdata, f_mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_we, busy, f_mem_we, f_busy;
  int          errors = 0;
  int          checks = 0;

  logic [15:0] ram [0:516];
  logic        bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [15:0] bd_dat = '0;

  mem_arbiter_if #(.AW(11), .DW(16)) p0_if ();
  mem_arbiter_if #(.AW(11), .DW(16)) p1_if ();
  mem_arbiter_if #(.AW(11), .DW(16)) f0_if ();
  mem_arbiter_if #(.AW(11), .DW(16)) f1_if ();

  mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset_bar(reset_bar), .p0(p0_if.slave), .p1(p1_if.slave),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset_bar(reset_bar), .p0(f0_if.slave), .p1(f1_if.slave),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_we(f_mem_we),
    .mem_rdata(16'h0000), .busy(f_busy)
  );

  always #5 clk = ~clk;

  // RAM: 0..0x204 backed, writes on negedge, registered reads on posedge, 16'hDEAD past the end.
  always @(negedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_dat;
    else if (mem_we && mem_addr <= 11'h204) ram[mem_addr] <= mem_wdata;
  end
  always @(posedge clk) mem_rdata <= (mem_addr <= 11'h204) ? ram[mem_addr] : 16'hDEAD;

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    bd_addr = a; bd_dat = d; bd_we = 1'b1;
    @(negedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic set_req(input bit port, input bit r, input bit w, input logic [10:0] a, input logic [15:0] d);
    if (port) begin p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d; end
    else      begin p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d; end
  endtask

  // One access from an idle arbiter; cyc counts posedges after the request is driven (10 if it never completes).
  task automatic access(input bit port, input bit w, input logic [10:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic er, output int cyc, output int we_cnt,
                        output int we_cyc, output bit other_done, output bit done_stuck);
    rd = 'x; er = 1'bx; cyc = 0; we_cnt = 0; we_cyc = -1; other_done = 1'b0;
    set_req(port, 1'b1, w, a, d);
    repeat (10) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_we) begin we_cnt++; we_cyc = cyc; end
      if (port ? p0_if.done : p1_if.done) other_done = 1'b1;
      if (port ? p1_if.done : p0_if.done) begin
        rd = port ? p1_if.rdata : p0_if.rdata;
        er = port ? p1_if.err : p0_if.err;
        break;
      end
    end
    set_req(port, 1'b0, w, a, d);
    @(posedge clk); #1;
    done_stuck = port ? p1_if.done : p0_if.done;
    if (mem_we) we_cnt++;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 11'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
    checks++; if ({p0_if.done, p1_if.done, p0_if.err, p1_if.err} !== 4'b0000) begin errors++; $display("FAIL reset_done_err: got %b want 0000", {p0_if.done, p1_if.done, p0_if.err, p1_if.err}); end
    checks++; if (p0_if.rdata !== 16'h0000) begin errors++; $display("FAIL reset_p0_rdata: got %h want 0000", p0_if.rdata); end
    checks++; if (p1_if.rdata !== 16'h0000) begin errors++; $display("FAIL reset_p1_rdata: got %h want 0000", p1_if.rdata); end
  endtask

  task automatic test_single_read();
    logic [15:0] rd; logic er; int cyc, wc, wcyc; bit od, ds;
    access(1'b0, 1'b0, 11'h010, 16'h0000, rd, er, cyc, wc, wcyc, od, ds);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL read_latency: got %0d want 2", cyc); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL read_data: got %h want 1234", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", er); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL read_mem_we: got %0d cycles want 0", wc); end
    checks++; if (ds !== 1'b0) begin errors++; $display("FAIL read_done_pulse: got %b want 0", ds); end
    checks++; if (p0_if.rdata !== 16'h1234) begin errors++; $display("FAIL read_held: got %h want 1234", p0_if.rdata); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic er; int cyc, wc, wcyc; bit od, ds;
    access(1'b1, 1'b1, 11'h020, 16'hBEEF, rd, er, cyc, wc, wcyc, od, ds);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2", cyc); end
    checks++; if (wc !== 1 || wcyc !== 1) begin errors++; $display("FAIL write_mem_we: got %0d cycles at %0d want 1 at 1", wc, wcyc); end
    checks++; if (ram[11'h020] !== 16'hBEEF) begin errors++; $display("FAIL write_ram: got %h want beef", ram[11'h020]); end
    checks++; if (od !== 1'b0) begin errors++; $display("FAIL write_p0_done: got %b want 0", od); end
    access(1'b1, 1'b0, 11'h020, 16'h0000, rd, er, cyc, wc, wcyc, od, ds);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL readback_data: got %h want beef", rd); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL readback_mem_we: got %0d want 0", wc); end
    checks++; if (od !== 1'b0) begin errors++; $display("FAIL readback_p0_done: got %b want 0", od); end
  endtask

  task automatic test_contention_rr();
    set_req(1'b0, 1'b1, 1'b0, 11'h030, 16'h0000);
    set_req(1'b1, 1'b1, 1'b0, 11'h031, 16'h0000);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      checks++; if (p0_if.done !== (c == 2 || c == 8)) begin errors++; $display("FAIL rr_p0_done c%0d: got %b want %b", c, p0_if.done, (c == 2 || c == 8)); end
      checks++; if (p1_if.done !== (c == 5 || c == 11)) begin errors++; $display("FAIL rr_p1_done c%0d: got %b want %b", c, p1_if.done, (c == 5 || c == 11)); end
      if (c == 2) begin checks++; if (p0_if.rdata !== 16'h3030) begin errors++; $display("FAIL rr_p0_rdata: got %h want 3030", p0_if.rdata); end end
      if (c == 5) begin checks++; if (p1_if.rdata !== 16'h3131) begin errors++; $display("FAIL rr_p1_rdata: got %h want 3131", p1_if.rdata); end end
    end
    set_req(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 11'h000, 16'h0000);
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_prio();
    f0_if.req = 1'b1; f0_if.we = 1'b0; f0_if.addr = 11'h011; f0_if.wdata = 16'h0F0F;
    f1_if.req = 1'b1; f1_if.we = 1'b0; f1_if.addr = 11'h022; f1_if.wdata = 16'h1F1F;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      checks++; if (f0_if.done !== (c == 2 || c == 5 || c == 8)) begin errors++; $display("FAIL fp_p0_done c%0d: got %b want %b", c, f0_if.done, (c == 2 || c == 5 || c == 8)); end
      checks++; if (f1_if.done !== (c == 11)) begin errors++; $display("FAIL fp_p1_done c%0d: got %b want %b", c, f1_if.done, (c == 11)); end
      if (c == 1) begin
        checks++; if (f_mem_addr !== 11'h011 || f_mem_wdata !== 16'h0F0F) begin errors++; $display("FAIL fp_latch: got %h/%h want 011/0f0f", f_mem_addr, f_mem_wdata); end
        checks++; if (f_busy !== 1'b1 || f_mem_we !== 1'b0) begin errors++; $display("FAIL fp_busy_we: got %b%b want 10", f_busy, f_mem_we); end
      end
      if (c == 8) f0_if.req = 1'b0;
    end
    f1_if.req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic er; int cyc, wc, wcyc; bit od, ds;
    access(1'b0, 1'b1, 11'h300, 16'h5555, rd, er, cyc, wc, wcyc, od, ds);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL oor_latency: got %0d want 2", cyc); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL oor_mem_we: got %0d want 0", wc); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", er); end
    checks++; if (rd !== 16'hDEAD) begin errors++; $display("FAIL oor_rdata: got %h want dead", rd); end
    checks++; if (ram[11'h204] !== 16'h0204) begin errors++; $display("FAIL oor_ram: got %h want 0204", ram[11'h204]); end
    access(1'b0, 1'b1, 11'h204, 16'h4444, rd, er, cyc, wc, wcyc, od, ds);
    checks++; if (er !== 1'b0 || wc !== 1) begin errors++; $display("FAIL max_addr_write: got err=%b we=%0d want 0/1", er, wc); end
    checks++; if (ram[11'h204] !== 16'h4444) begin errors++; $display("FAIL max_addr_ram: got %h want 4444", ram[11'h204]); end
    access(1'b0, 1'b0, 11'h205, 16'h0000, rd, er, cyc, wc, wcyc, od, ds);
    checks++; if (er !== 1'b1 || rd !== 16'hDEAD) begin errors++; $display("FAIL past_max_read: got err=%b data=%h want 1/dead", er, rd); end
  endtask

  task automatic test_reset_mid();
    set_req(1'b0, 1'b1, 1'b1, 11'h040, 16'h2222);
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b want 1", mem_we); end
    reset_bar = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_abort: got we=%b busy=%b want 0/0", mem_we, busy); end
    set_req(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    @(negedge clk); #1;
    checks++; if (ram[11'h040] !== 16'h1111) begin errors++; $display("FAIL rst_ram: got %h want 1111", ram[11'h040]); end
    reset_bar = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got busy=%b want 0", busy); end
    set_req(1'b0, 1'b1, 1'b0, 11'h040, 16'h0000);
    set_req(1'b1, 1'b1, 1'b0, 11'h010, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      checks++; if (p0_if.done !== (c == 2)) begin errors++; $display("FAIL rst_p0_first c%0d: got %b want %b", c, p0_if.done, (c == 2)); end
      checks++; if (p1_if.done !== (c == 5)) begin errors++; $display("FAIL rst_p1_next c%0d: got %b want %b", c, p1_if.done, (c == 5)); end
      if (c == 2) begin checks++; if (p0_if.rdata !== 16'h1111) begin errors++; $display("FAIL rst_p0_rdata: got %h want 1111", p0_if.rdata); end end
    end
    set_req(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 11'h000, 16'h0000);
    @(posedge clk); #1;
  endtask

  task automatic test_held_data();
    logic [15:0] rd; logic er; int cyc, wc, wcyc; bit od, ds;
    access(1'b0, 1'b0, 11'h050, 16'h0000, rd, er, cyc, wc, wcyc, od, ds);
    checks++; if (rd !== 16'hAAAA) begin errors++; $display("FAIL held_first: got %h want aaaa", rd); end
    set_req(1'b1, 1'b1, 1'b0, 11'h010, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      checks++; if (p0_if.rdata !== 16'hAAAA) begin errors++; $display("FAIL held_p0_rdata c%0d: got %h want aaaa", c, p0_if.rdata); end
      checks++; if (p1_if.done !== (c == 2 || c == 5 || c == 8)) begin errors++; $display("FAIL held_p1_done c%0d: got %b want %b", c, p1_if.done, (c == 2 || c == 5 || c == 8)); end
    end
    set_req(1'b1, 1'b0, 1'b0, 11'h000, 16'h0000);
    @(posedge clk); #1;
    checks++; if (p1_if.rdata !== 16'h1234) begin errors++; $display("FAIL held_p1_rdata: got %h want 1234", p1_if.rdata); end
  endtask

  initial begin
    reset_bar = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 11'h000, 16'h0000);
    f0_if.req = 1'b0; f0_if.we = 1'b0; f0_if.addr = '0; f0_if.wdata = '0;
    f1_if.req = 1'b0; f1_if.we = 1'b0; f1_if.addr = '0; f1_if.wdata = '0;
    test_reset();
    @(negedge clk);
    reset_bar = 1'b1;
    poke(11'h010, 16'h1234);
    poke(11'h030, 16'h3030);
    poke(11'h031, 16'h3131);
    poke(11'h040, 16'h1111);
    poke(11'h050, 16'hAAAA);
    poke(11'h204, 16'h0204);
    @(posedge clk); #1;
    test_single_read();
    test_write_read();
    test_contention_rr();
    test_fixed_prio();
    test_out_of_range();
    test_reset_mid();
    test_held_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
